// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer in front of a shared WIDTH-bit register.
// Requesters use a req/gnt/ack handshake; one write is committed per grant.
module dff_reg_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           ack,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic [CNT_W-1:0]          wr_cnt
);

    localparam int unsigned OW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [OW-1:0]    last;
    logic [OW-1:0]    sel;
    logic [OW-1:0]    cand;
    logic [OW-1:0]    win_idx;
    logic             win_found;
    logic [WIDTH-1:0] sel_data;

    // Scan starting just after the last committed writer, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = OW'((32'(last) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign sel_data = wdata[32'(sel)*WIDTH +: WIDTH];

    // Arbitration, commit and ack sequencing; sel holds the granted index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
            wr_cnt  <= '0;
            last    <= OW'(NREQ - 1);
            sel     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (win_found) begin
                        gnt   <= NREQ'(1) << win_idx;
                        sel   <= win_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    // A dropped request aborts the grant without touching the pointer.
                    if (req[sel]) begin
                        q       <= sel_data;
                        ack     <= NREQ'(1) << sel;
                        owner   <= sel;
                        last    <= sel;
                        q_valid <= 1'b1;
                        wr_cnt  <= wr_cnt + CNT_W'(1);
                        state   <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboard bench for dff_reg_arbiter: stimulus queues expected commits,
// a negedge monitor checks each ack plus the register and handshake invariants.
module tb_dff_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;

    logic [3:0]  gnt, ack, gnt2, ack2;
    logic [7:0]  q, q2;
    logic        q_valid, q_valid2;
    logic [1:0]  owner, owner2;
    logic [7:0]  wr_cnt;
    logic [1:0]  wr_cnt2;

    dff_reg_arbiter #(.NREQ(4), .WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .q_valid(q_valid),
        .owner(owner), .wr_cnt(wr_cnt)
    );

    dff_reg_arbiter #(.NREQ(4), .WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt2), .ack(ack2), .q(q2), .q_valid(q_valid2),
        .owner(owner2), .wr_cnt(wr_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] q;
        int         cnt;
        int         gap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;
    int   exp_cnt = 0;
    logic [7:0] exp_q = '0;
    logic       exp_qv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected commit per ack and tracks the register model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q  = '0;
            exp_qv = 1'b0;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
            chk("gnt_ack_exclusive", 32'((|gnt) && (|ack)), 32'd0);
            if (ack != 4'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack", 32'(ack), 32'(4'b0001 << e.owner));
                    chk("owner", 32'(owner), 32'(e.owner));
                    chk("wr_cnt", 32'(wr_cnt), 32'(e.cnt % 256));
                    chk("ack_w2", 32'(ack2), 32'(4'b0001 << e.owner));
                    chk("owner_w2", 32'(owner2), 32'(e.owner));
                    chk("wr_cnt_w2", 32'(wr_cnt2), 32'(e.cnt % 4));
                    if (e.gap != 0)
                        chk("commit_gap", 32'(cyc - last_ack_cyc), 32'(e.gap));
                    exp_q  = e.q;
                    exp_qv = 1'b1;
                end
                last_ack_cyc = cyc;
            end
            chk("q", 32'(q), 32'(exp_q));
            chk("q_valid", 32'(q_valid), 32'(exp_qv));
            chk("q_w2", 32'(q2), 32'(exp_q));
            chk("q_valid_w2", 32'(q_valid2), 32'(exp_qv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        wdata[i*8 +: 8] = v;
    endtask

    task automatic push(input logic [1:0] o, input logic [7:0] d, input int gap);
        exp_t x;
        exp_cnt++;
        x.owner = o;
        x.q     = d;
        x.cnt   = exp_cnt;
        x.gap   = gap;
        sb.push_back(x);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic chk_gnt(input string name, input logic [3:0] exp);
        chk(name, 32'(gnt), 32'(exp));
        chk({name, "_w2"}, 32'(gnt2), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        wdata = '0;

        // 1: reset state, idle with no requests
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_gnt("idle_gnt", 4'b0000);
            chk("idle_ack", 32'(ack), 32'd0);
        end
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_q_valid", 32'(q_valid), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_wr_cnt_w2", 32'(wr_cnt2), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);

        // 2: single requester 2
        set_data(2, 8'hA5);
        req = 4'b0100;
        push(2'd2, 8'hA5, 0);
        tick();
        chk_gnt("single_gnt", 4'b0100);
        chk("single_ack_early", 32'(ack), 32'd0);
        tick();
        chk_gnt("single_gnt_cleared", 4'b0000);
        req = 4'b0000;
        drain(10);
        chk("single_ack_cleared", 32'(ack), 32'd0);
        tick();
        tick();
        chk_gnt("single_idle_gnt", 4'b0000);

        // 3 and 6: all requesting from reset, rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
        req = 4'b1111;
        push(2'd0, 8'h10, 0);
        push(2'd1, 8'h11, 3);
        push(2'd2, 8'h12, 3);
        push(2'd3, 8'h13, 3);
        push(2'd0, 8'h10, 3);
        drain(40);
        req = 4'b0000;
        tick();
        tick();
        chk_gnt("rr_no_extra_gnt", 4'b0000);
        chk("rr_wr_cnt_final", 32'(wr_cnt), 32'd5);
        chk("rr_wr_cnt_w2_final", 32'(wr_cnt2), 32'd1);

        // 4: abort during GRANT leaves pointer, q and count alone
        req = 4'b0010;
        tick();
        chk_gnt("abort_gnt", 4'b0010);
        req = 4'b0000;
        tick();
        chk_gnt("abort_gnt_cleared", 4'b0000);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_q", 32'(q), 32'h10);
        chk("abort_wr_cnt", 32'(wr_cnt), 32'd5);
        chk("abort_owner", 32'(owner), 32'd0);
        tick();
        chk("abort_ack_later", 32'(ack), 32'd0);
        chk_gnt("abort_idle_gnt", 4'b0000);
        req = 4'b1110;
        push(2'd1, 8'h11, 0);
        tick();
        chk_gnt("post_abort_gnt", 4'b0010);
        tick();
        req = 4'b0000;
        drain(10);

        // 5: reset while requester 3 is granted
        req = 4'b1000;
        tick();
        chk_gnt("pre_rst_gnt", 4'b1000);
        rst = 1'b1;
        #2;
        chk_gnt("midrst_gnt", 4'b0000);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("midrst_q_valid", 32'(q_valid), 32'd0);
        exp_cnt = 0;
        tick();
        rst = 1'b0;
        req = 4'b1001;
        push(2'd0, 8'h10, 0);
        tick();
        chk_gnt("post_rst_gnt", 4'b0001);
        tick();
        req = 4'b0000;
        drain(10);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
